// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage feeding the ALU, registered behind a 2-entry skid buffer.
// Optional DECODE_STATS_EN adds issue_count / illegal_count transfer counters.
//
// state | meaning
// EMPTY | no entry held, out_valid=0, in_ready=1
// ONE   | main register holds the output entry
// TWO   | main + skid both valid, in_ready=0
module alu_decode_stage #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [WIDTH-1:0]    pc,
    input  logic [WIDTH-1:0]    rs1_data,
    input  logic [WIDTH-1:0]    rs2_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [4:0]          rd,
    output logic                rd_we,
    output logic                illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]         issue_count,
    output logic [31:0]         illegal_count
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0] op;
        logic [WIDTH-1:0]    a;
        logic [WIDTH-1:0]    b;
        logic [4:0]          rd;
        logic                rd_we;
        logic                illegal;
    } entry_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    state_t              state;
    entry_t              main_q;
    entry_t              skid_q;
    entry_t              dec;
    logic                legal;
    logic [OP_WIDTH-1:0] op_c;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                in_fire;
    logic                out_fire;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        op_c   = '0;
        dec.rd = instr[11:7];
        case (opcode)
            OPC_R: begin
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                op_c  = OP_WIDTH'({instr[30], funct3, 1'b1});
                dec.a = rs1_data;
                dec.b = rs2_data;
            end
            OPC_I: begin
                dec.a = rs1_data;
                op_c  = OP_WIDTH'({1'b0, funct3, 1'b1});
                dec.b = WIDTH'($signed(instr[31:20]));
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                    dec.b = WIDTH'(instr[24:20]);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    op_c  = OP_WIDTH'({instr[30], funct3, 1'b1});
                    dec.b = WIDTH'(instr[24:20]);
                end else begin
                    legal = 1'b1;
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                op_c  = OP_WIDTH'(5'b00001);
                dec.b = WIDTH'($signed({instr[31:12], 12'b0}));
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op_c  = OP_WIDTH'(5'b00001);
                dec.a = pc;
                dec.b = WIDTH'($signed({instr[31:12], 12'b0}));
            end
            default: legal = 1'b0;
        endcase
        // Illegal entries still travel the pipe, but as a harmless no-op.
        if (legal) begin
            dec.op    = op_c;
            dec.rd_we = (instr[11:7] != 5'd0);
        end else begin
            dec.op      = '0;
            dec.a       = '0;
            dec.b       = '0;
            dec.rd_we   = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q    <= dec;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_q   <= dec;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (out_fire && !in_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end else if (in_fire && out_fire) begin
                        main_q <= dec;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign alu_op  = main_q.op;
    assign alu_a   = main_q.a;
    assign alu_b   = main_q.b;
    assign rd      = main_q.rd;
    assign rd_we   = main_q.rd_we;
    assign illegal = main_q.illegal;

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count   <= '0;
            illegal_count <= '0;
        end else if (out_fire) begin
            issue_count <= issue_count + 32'd1;
            if (main_q.illegal) begin
                illegal_count <= illegal_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: decode vector table plus handshake,
// flush and asynchronous reset sequences (counters checked when DECODE_STATS_EN).
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
`ifdef DECODE_STATS_EN
    logic [31:0] issue_count;
    logic [31:0] illegal_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    alu_decode_stage #(.WIDTH(32), .OP_WIDTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
`ifdef DECODE_STATS_EN
        ,
        .issue_count   (issue_count),
        .illegal_count (illegal_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input string nm, input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] op,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                                input logic we, input logic ill);
        vec_t v;
        v.nm = nm; v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
        v.op = op; v.a = a; v.b = b; v.rd = d; v.we = we; v.ill = ill;
        return v;
    endfunction

    function automatic logic [31:0] add_rd(input logic [4:0] r);
        return 32'h0020_8033 | (32'(r) << 7);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_alu_op"},    32'(alu_op),    32'd0);
        chk({tag, "_alu_a"},     alu_a,          32'd0);
        chk({tag, "_alu_b"},     alu_b,          32'd0);
        chk({tag, "_rd"},        32'(rd),        32'd0);
        chk({tag, "_rd_we"},     32'(rd_we),     32'd0);
        chk({tag, "_illegal"},   32'(illegal),   32'd0);
    endtask

    // Send one instruction with the consumer ready and wait until it has drained.
    task automatic transfer(input logic [31:0] i);
        out_ready = 1'b1;
        drive(i, 32'd1, 32'd2);
        step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [4:0] got[8];
        int         n_got;
        int         ghost;
        logic       acc;
        logic       fire;

        vecs[0]  = mk("add",        32'h0020_81B3, 32'h0,   32'd5,         32'd7,  5'b00001, 32'd5,         32'd7,         5'd3,  1'b1, 1'b0);
        vecs[1]  = mk("sub",        32'h4020_81B3, 32'h0,   32'd5,         32'd7,  5'b10001, 32'd5,         32'd7,         5'd3,  1'b1, 1'b0);
        vecs[2]  = mk("addi_m1",    32'hFFF0_0293, 32'h0,   32'd0,         32'd9,  5'b00001, 32'd0,         32'hFFFF_FFFF, 5'd5,  1'b1, 1'b0);
        vecs[3]  = mk("srai",       32'h4040_D313, 32'h0,   32'h8000_0000, 32'd9,  5'b11011, 32'h8000_0000, 32'd4,         5'd6,  1'b1, 1'b0);
        vecs[4]  = mk("lui",        32'h1234_53B7, 32'h0,   32'hDEAD_BEEF, 32'd9,  5'b00001, 32'd0,         32'h1234_5000, 5'd7,  1'b1, 1'b0);
        vecs[5]  = mk("all_ones",   32'hFFFF_FFFF, 32'h0,   32'd5,         32'd7,  5'b00000, 32'd0,         32'd0,         5'd0,  1'b0, 1'b1);
        vecs[6]  = mk("auipc",      32'h0000_1517, 32'h100, 32'd5,         32'd7,  5'b00001, 32'h100,       32'h1000,      5'd10, 1'b1, 1'b0);
        vecs[7]  = mk("add_x0",     32'h0020_8033, 32'h0,   32'd5,         32'd7,  5'b00001, 32'd5,         32'd7,         5'd0,  1'b0, 1'b0);
        vecs[8]  = mk("xor_f7bad",  32'h4020_C1B3, 32'h0,   32'd5,         32'd7,  5'b00000, 32'd0,         32'd0,         5'd0,  1'b0, 1'b1);
        vecs[9]  = mk("slli",       32'h0020_9193, 32'h0,   32'd5,         32'd7,  5'b00011, 32'd5,         32'd2,         5'd3,  1'b1, 1'b0);
        vecs[10] = mk("slli_f7bad", 32'h4020_9193, 32'h0,   32'd5,         32'd7,  5'b00000, 32'd0,         32'd0,         5'd0,  1'b0, 1'b1);
        vecs[11] = mk("sltiu",      32'hFFF0_B193, 32'h0,   32'd5,         32'd7,  5'b00111, 32'd5,         32'hFFFF_FFFF, 5'd3,  1'b1, 1'b0);
        vecs[12] = mk("and",        32'h0020_F1B3, 32'h0,   32'd5,         32'd7,  5'b01111, 32'd5,         32'd7,         5'd3,  1'b1, 1'b0);
        vecs[13] = mk("srl",        32'h0020_D1B3, 32'h0,   32'd5,         32'd7,  5'b01011, 32'd5,         32'd7,         5'd3,  1'b1, 1'b0);
        vecs[14] = mk("sra",        32'h4020_D1B3, 32'h0,   32'd5,         32'd7,  5'b11011, 32'd5,         32'd7,         5'd3,  1'b1, 1'b0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'd0;
        pc        = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (vecs[k]) begin
            pc        = vecs[k].pc;
            out_ready = 1'b1;
            drive(vecs[k].instr, vecs[k].rs1, vecs[k].rs2);
            step();
            in_valid = 1'b0;
            chk({vecs[k].nm, "_valid"},   32'(out_valid), 32'd1);
            chk({vecs[k].nm, "_op"},      32'(alu_op),    32'(vecs[k].op));
            chk({vecs[k].nm, "_a"},       alu_a,          vecs[k].a);
            chk({vecs[k].nm, "_b"},       alu_b,          vecs[k].b);
            chk({vecs[k].nm, "_rd_we"},   32'(rd_we),     32'(vecs[k].we));
            chk({vecs[k].nm, "_illegal"}, 32'(illegal),   32'(vecs[k].ill));
            if (!vecs[k].ill) chk({vecs[k].nm, "_rd"}, 32'(rd), 32'(vecs[k].rd));
            step();
            chk({vecs[k].nm, "_drained"}, 32'(out_valid), 32'd0);
        end
        pc = 32'd0;

        // Backpressure: two entries fill the buffer, the third waits.
        out_ready = 1'b0;
        drive(add_rd(5'd1), 32'd1, 32'd1);
        chk("bp_ready0", 32'(in_ready), 32'd1);
        step();
        drive(add_rd(5'd2), 32'd2, 32'd2);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        chk("bp_valid1", 32'(out_valid), 32'd1);
        step();
        drive(add_rd(5'd3), 32'd3, 32'd3);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        step();
        step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold_rd", 32'(rd), 32'd1);
        chk("bp_hold_a", alu_a, 32'd1);
        out_ready = 1'b1;
        n_got = 0;
        for (int c = 0; c < 12; c++) begin
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                if (n_got < 8) got[n_got] = rd;
                n_got++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("bp_count", 32'(n_got), 32'd3);
        if (n_got >= 3) begin
            chk("bp_order0", 32'(got[0]), 32'd1);
            chk("bp_order1", 32'(got[1]), 32'd2);
            chk("bp_order2", 32'(got[2]), 32'd3);
        end
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush from TWO with a concurrent valid input.
        out_ready = 1'b0;
        drive(add_rd(5'd4), 32'd4, 32'd4);
        step();
        drive(add_rd(5'd5), 32'd5, 32'd5);
        step();
        drive(add_rd(5'd6), 32'd6, 32'd6);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2_valid", 32'(out_valid), 32'd0);
        chk("flush2_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        ghost = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) ghost++;
            step();
        end
        chk("flush2_no_ghost", 32'(ghost), 32'd0);

        // Flush from ONE with an in_fire in the same cycle.
        out_ready = 1'b0;
        drive(add_rd(5'd8), 32'd8, 32'd8);
        step();
        drive(add_rd(5'd9), 32'd9, 32'd9);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush1_valid", 32'(out_valid), 32'd0);
        drive(add_rd(5'd11), 32'd11, 32'd11);
        step();
        in_valid = 1'b0;
        chk("post_flush_rd", 32'(rd), 32'd11);
        chk("post_flush_a", alu_a, 32'd11);
        out_ready = 1'b1;
        step();
        chk("post_flush_empty", 32'(out_valid), 32'd0);

`ifdef DECODE_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("stats_reset_issue", issue_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        transfer(add_rd(5'd1));
        transfer(add_rd(5'd2));
        transfer(32'hFFFF_FFFF);
        transfer(add_rd(5'd3));
        chk("stats_issue", issue_count, 32'd4);
        chk("stats_illegal", illegal_count, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stats_flush_issue", issue_count, 32'd4);
        chk("stats_flush_illegal", illegal_count, 32'd1);
`endif

        // Asynchronous reset while an entry is stalled at the output.
        out_ready = 1'b0;
        drive(add_rd(5'd7), 32'd7, 32'd7);
        step();
        in_valid = 1'b0;
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        chk("arst_pre_rd", 32'(rd), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("arst");
`ifdef DECODE_STATS_EN
        chk("arst_issue", issue_count, 32'd0);
        chk("arst_illegal", illegal_count, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_release_valid", 32'(out_valid), 32'd0);
        chk("arst_release_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
